// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Operation codes, FSM states and helpers shared by alu_seq.
// Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'h00,
        OP_SUB    = 5'h01,
        OP_AND    = 5'h02,
        OP_OR     = 5'h03,
        OP_XOR    = 5'h04,
        OP_SLL    = 5'h05,
        OP_SRL    = 5'h06,
        OP_SRA    = 5'h07,
        OP_BEQ    = 5'h08,
        OP_BNE    = 5'h09,
        OP_BLT    = 5'h0A,
        OP_BGE    = 5'h0B,
        OP_BLTU   = 5'h0C,
        OP_BGEU   = 5'h0D,
        OP_LUI    = 5'h0F,
        OP_MUL    = 5'h10,
        OP_MULH   = 5'h11,
        OP_MULHSU = 5'h12,
        OP_MULHU  = 5'h13,
        OP_DIV    = 5'h14,
        OP_DIVU   = 5'h15,
        OP_REM    = 5'h16,
        OP_REMU   = 5'h17
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // MDU codes occupy 0x10..0x17; 0x18..0x1F fall through to the base path.
    function automatic logic is_mdu(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative shift-add multiplier / restoring divider on operand
//               magnitudes, with final sign fix. XLEN steps plus one finish cycle.
// Revision    : 1.0  initial release
// ============================================================================
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic [2:0]      fn_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int            CW     = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] C_ITER = CW'(XLEN);

    logic [CW-1:0]   cnt_q;
    logic            active_q;
    logic [2:0]      fn_q;
    logic            neg_q;
    logic            neg_rem_q;
    logic            dbz_q;
    logic [XLEN-1:0] m_q;
    logic [XLEN:0]   hi_q;
    logic [XLEN-1:0] lo_q;

    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic [XLEN:0]   w_sum, w_shift, w_diff;
    logic            w_ge;
    logic [2*XLEN-1:0] w_prod, w_prod_s;
    logic [XLEN-1:0] w_quot, w_rem;

    // fn[2] selects divide; fn[0]=1 marks the unsigned divide forms.
    assign w_a_signed = fn_i[2] ? ~fn_i[0] : (fn_i[1:0] != 2'b11);
    assign w_b_signed = fn_i[2] ? ~fn_i[0] : ~fn_i[1];
    assign w_a_neg    = w_a_signed & a_i[XLEN-1];
    assign w_b_neg    = w_b_signed & b_i[XLEN-1];
    assign w_a_mag    = w_a_neg ? -a_i : a_i;
    assign w_b_mag    = w_b_neg ? -b_i : b_i;

    assign w_sum   = hi_q + (lo_q[0] ? {1'b0, m_q} : '0);
    assign w_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, m_q};
    assign w_ge    = (w_shift >= {1'b0, m_q});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            active_q  <= 1'b0;
            fn_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (flush_i) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            cnt_q     <= C_ITER;
            active_q  <= 1'b1;
            fn_q      <= fn_i;
            neg_q     <= w_a_neg ^ w_b_neg;
            neg_rem_q <= w_a_neg;
            dbz_q     <= (b_i == '0);
            hi_q      <= '0;
            lo_q      <= fn_i[2] ? w_a_mag : w_b_mag;
            m_q       <= fn_i[2] ? w_b_mag : w_a_mag;
        end else if (active_q) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
                if (fn_q[2]) begin
                    hi_q <= w_ge ? w_diff : w_shift;
                    lo_q <= {lo_q[XLEN-2:0], w_ge};
                end else begin
                    hi_q <= {1'b0, w_sum[XLEN:1]};
                    lo_q <= {w_sum[0], lo_q[XLEN-1:1]};
                end
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign done_o   = active_q && (cnt_q == '0);
    assign w_prod   = {hi_q[XLEN-1:0], lo_q};
    assign w_prod_s = neg_q ? -w_prod : w_prod;
    assign w_quot   = dbz_q ? '1 : (neg_q ? -lo_q : lo_q);
    assign w_rem    = neg_rem_q ? -hi_q[XLEN-1:0] : hi_q[XLEN-1:0];

    always_comb begin
        result_o = '0;
        case (fn_q)
            3'd0:                   result_o = w_prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3:       result_o = w_prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:             result_o = w_quot;
            default:                result_o = w_rem;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Multi-cycle EX-stage ALU: single-cycle base/branch ops plus
//               iterative RV32M/RV64M multiply/divide behind valid/ready.
// Revision    : 1.0  initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [4:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] resC,
    output logic            branch
);

    state_e          state_q;
    logic            out_valid_q;
    logic [XLEN-1:0] resC_q;
    logic            branch_q;

    logic            w_accept;
    logic            w_mdu_start;
    logic            w_mdu_done;
    logic [XLEN-1:0] w_mdu_res;
    logic [XLEN-1:0] w_base_res;
    logic            w_base_br;
    logic [SHW-1:0]  w_sh;

    assign in_ready    = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign w_accept    = in_valid && in_ready && !flush;
    assign w_mdu_start = w_accept && is_mdu(op);
    assign w_sh        = opB[SHW-1:0];

    always_comb begin
        w_base_res = '0;
        w_base_br  = 1'b0;
        case (op)
            OP_ADD:  w_base_res = opA + opB;
            OP_SUB:  w_base_res = opA - opB;
            OP_AND:  w_base_res = opA & opB;
            OP_OR:   w_base_res = opA | opB;
            OP_XOR:  w_base_res = opA ^ opB;
            OP_SLL:  w_base_res = opA << w_sh;
            OP_SRL:  w_base_res = opA >> w_sh;
            OP_SRA:  w_base_res = XLEN'($signed(opA) >>> w_sh);
            OP_BEQ:  w_base_br  = (opA == opB);
            OP_BNE:  w_base_br  = (opA != opB);
            OP_BLT:  w_base_br  = ($signed(opA) < $signed(opB));
            OP_BGE:  w_base_br  = ($signed(opA) >= $signed(opB));
            OP_BLTU: w_base_br  = (opA < opB);
            OP_BGEU: w_base_br  = (opA >= opB);
            OP_LUI:  w_base_res = opB;
            default: begin
                w_base_res = '0;
                w_base_br  = 1'b0;
            end
        endcase
    end

    mdu_iter #(
        .XLEN (XLEN)
    ) u_mdu (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush),
        .start_i  (w_mdu_start),
        .fn_i     (op[2:0]),
        .a_i      (opA),
        .b_i      (opB),
        .done_o   (w_mdu_done),
        .result_o (w_mdu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            resC_q      <= '0;
            branch_q    <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            resC_q      <= '0;
            branch_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        if (is_mdu(op)) begin
                            state_q     <= ST_BUSY;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                            resC_q      <= w_base_res;
                            branch_q    <= w_base_br;
                        end
                    end else if (state_q == ST_DONE && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (w_mdu_done) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        resC_q      <= w_mdu_res;
                        branch_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign resC      = resC_q;
    assign branch    = branch_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq (XLEN = 32): vector table,
//               result scoreboard, handshake / flush / reset sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        br;
    } vec_t;

    typedef struct packed {
        logic [31:0] res;
        logic        br;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic [4:0]  op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] resC;
    logic        branch;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t vq[$];

    alu_seq #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .resC      (resC),
        .branch    (branch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Each negedge with a pending handshake retires one result at the next edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", {32'h0, resC}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_resC", {32'h0, resC}, {32'h0, e.res});
                chk("sb_branch", {63'h0, branch}, {63'h0, e.br});
            end
        end
    end

    task automatic add(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic br);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.res = r; v.br = br;
        vq.push_back(v);
    endtask

    task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; op = o; opA = a; opB = b;
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("in_ready_timeout", 64'd0, 64'd1);
    endtask

    // Drive one op, scoreboard its result and check the accept-to-valid latency.
    task automatic run_vec(input vec_t v);
        bit ok;
        bit busy_ok;
        int low;
        int exp_low;
        exp_t e;
        exp_low = (v.op[4:3] == 2'b10) ? 33 : 0;
        @(posedge clk); #1;
        drive(v.op, v.a, v.b);
        wait_ready(ok);
        if (!ok) begin
            in_valid = 1'b0;
            return;
        end
        e.res = v.res; e.br = v.br;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        low = 0;
        busy_ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid) break;
            low++;
            if (in_ready) busy_ok = 1'b0;
        end
        chk($sformatf("latency_op%02h", v.op), 64'(low), 64'(exp_low));
        if (exp_low != 0) chk($sformatf("busy_in_ready_op%02h", v.op), {63'h0, busy_ok}, 64'd1);
    endtask

    initial begin
        bit   ok;
        exp_t e;
        int   seen;

        add(5'h00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
        add(5'h01, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0);
        add(5'h02, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0);
        add(5'h03, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0);
        add(5'h04, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0);
        add(5'h05, 32'h00000001, 32'h0000003F, 32'h80000000, 1'b0);
        add(5'h06, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0);
        add(5'h07, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0);
        add(5'h08, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1);
        add(5'h09, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
        add(5'h0A, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        add(5'h0B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        add(5'h0C, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0);
        add(5'h0D, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1);
        add(5'h0F, 32'h00000009, 32'h12345000, 32'h12345000, 1'b0);
        add(5'h0E, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
        add(5'h1F, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
        add(5'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        add(5'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        add(5'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        add(5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        add(5'h10, 32'h00000003, 32'hFFFFFFFB, 32'hFFFFFFF1, 1'b0);
        add(5'h14, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0);
        add(5'h16, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0);
        add(5'h15, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1'b0);
        add(5'h17, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0);
        add(5'h16, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1'b0);
        add(5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        add(5'h16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        add(5'h14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0);
        add(5'h16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0);
        add(5'h15, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0);
        add(5'h17, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("rst_resC", {32'h0, resC}, 64'd0);
        chk("rst_branch", {63'h0, branch}, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {63'h0, in_ready}, 64'd1);

        foreach (vq[i]) run_vec(vq[i]);

        // Output stall: result must hold while out_ready is low
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(5'h00, 32'h11, 32'h22);
        wait_ready(ok);
        e.res = 32'h33; e.br = 1'b0;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_out_valid", {63'h0, out_valid}, 64'd1);
            chk("stall_resC", {32'h0, resC}, 64'h33);
            chk("stall_in_ready", {63'h0, in_ready}, 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Back-to-back base ops, one result per cycle
        add(5'h00, 32'h1, 32'h1, 32'h2, 1'b0);
        add(5'h01, 32'h9, 32'h4, 32'h5, 1'b0);
        add(5'h04, 32'hF, 32'h3, 32'hC, 1'b0);
        add(5'h0F, 32'h0, 32'hABCD0000, 32'hABCD0000, 1'b0);
        for (int i = vq.size() - 4; i < vq.size(); i++) begin
            @(posedge clk); #1;
            drive(vq[i].op, vq[i].a, vq[i].b);
            @(negedge clk);
            chk("b2b_in_ready", {63'h0, in_ready}, 64'd1);
            if (i > vq.size() - 4) chk("b2b_out_valid", {63'h0, out_valid}, 64'd1);
            e.res = vq[i].res; e.br = vq[i].br;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_last_valid", {63'h0, out_valid}, 64'd1);

        // Flush at cycle 10 of a DIV: no result may ever appear
        @(posedge clk); #1;
        drive(5'h14, 32'd100, 32'd7);
        wait_ready(ok);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_div_no_valid", 64'(seen), 64'd0);

        // Flush together with in_valid: the op must be dropped
        @(posedge clk); #1;
        drive(5'h00, 32'h5, 32'h6);
        flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_override_no_valid", 64'(seen), 64'd0);

        add(5'h00, 32'h40, 32'h2, 32'h42, 1'b0);
        run_vec(vq[vq.size() - 1]);

        // Reset pulsed mid-MULH
        @(posedge clk); #1;
        drive(5'h11, 32'hFFFFFFFF, 32'h7);
        wait_ready(ok);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("mulh_busy_in_ready", {63'h0, in_ready}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'h0, out_valid}, 64'd0);
        chk("midrst_resC", {32'h0, resC}, 64'd0);
        chk("midrst_branch", {63'h0, branch}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        add(5'h00, 32'h2, 32'h3, 32'h5, 1'b0);
        run_vec(vq[vq.size() - 1]);
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("post_reset_no_stray_mulh", 64'(seen), 64'd0);

        for (int c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the CPU's combinational ALU. It executes the base integer and branch-compare operations in one registered cycle, and adds iterative multiply and divide (RV32M/RV64M semantics) that take several cycles. It sits in the EX stage between operand forwarding and the EX/MEM register, and uses a valid/ready handshake so the pipeline stalls while a multiply or divide is in flight.

## Interface
- XLEN, 32: operand and result width; must be 32 or 64.
- SHW, $clog2(XLEN): shift-amount bits taken from opB.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any accepted or in-flight operation
- in_valid  in  1  opA/opB/op are valid
- in_ready  out  1  unit accepts an operation this cycle
- opA  in  XLEN  operand A (rs1)
- opB  in  XLEN  operand B (rs2 or immediate)
- op  in  5  operation code (alu_pkg::alu_op_e)
- out_valid  out  1  resC/branch are valid
- out_ready  in  1  consumer takes the result
- resC  out  XLEN  arithmetic result
- branch  out  1  branch-taken flag

## Operation
- Op codes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR.
  - 0x05 SLL, 0x06 SRL, 0x07 SRA, using opB[SHW-1:0].
  - 0x08 BEQ, 0x09 BNE, 0x0A BLT (signed), 0x0B BGE (signed).
  - 0x0C BLTU, 0x0D BGEU (new), 0x0F LUI (resC = opB).
  - 0x10 MUL, 0x11 MULH, 0x12 MULHSU, 0x13 MULHU.
  - 0x14 DIV, 0x15 DIVU, 0x16 REM, 0x17 REMU.
  - Any other code yields resC = 0, branch = 0.
- Output registers are fully defined for every op, with no latched values:
  - Compare ops: resC = 0.
  - Non-compare ops: branch = 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of a base op (0x00–0x0F): result registered, go to DONE.
  - IDLE, accept of an MDU op: go to BUSY, load the iteration counter with XLEN.
  - BUSY: one shift-add (multiply) or restoring-subtract (divide) step per cycle. When the counter reaches 0, go to DONE.
  - DONE: out_valid = 1 and outputs hold stable. On out_ready, go to IDLE.
- Handshakes:
  - in_ready = (state == IDLE) || (state == DONE && out_ready).
  - Back-to-back accept in DONE is allowed.
  - An accept occurs when in_valid && in_ready && !flush.
- Signed MDU ops operate on magnitudes. The result is negated at the end when the operand signs require it.
- Divide corner cases:
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give opA. Still XLEN+1 cycles.
  - DIV with opA = −2^(XLEN−1) and opB = −1: quotient = opA, remainder = 0.
- Flush in any state forces IDLE and out_valid = 0. No result is emitted for the flushed operation. A flush overrides a simultaneous in_valid.

## Timing
- Reset (async, rst_n low): state = IDLE, out_valid = 0, resC = 0, branch = 0, counter = 0. in_ready = 1 one cycle after rst_n deasserts.
- Base op accepted at edge k: out_valid = 1 after edge k (latency 1).
- MDU op accepted at edge k: out_valid = 1 after edge k+XLEN+1 (33 cycles for XLEN = 32). in_ready stays 0 throughout BUSY.
- Output stall: resC, branch and out_valid hold unchanged until out_ready.
- Reset asserted mid-BUSY: immediate return to reset values, with no partial result visible.

## Structure
- alu_pkg holds:
  - alu_op_e, the 5-bit enum of the codes above;
  - the state_e enum;
  - the is_mdu(op) helper function.
- Sub-module mdu_iter holds the iterative multiply/divide datapath:
  - counter, accumulator, sign-fix;
  - start/done pulses.
- The top level holds the FSM, the base-op combinational block and the output registers.

## Test plan
- ADD 0x7FFFFFFF + 1 → resC 0x80000000, branch 0, out_valid one cycle after accept. SRA 0x80000000 by 4 → 0xF8000000.
- BLTU 0xFFFFFFFF < 1 → branch 0; BLT on the same operands → branch 1; resC 0 for both.
- MUL 0xFFFFFFFF × 0xFFFFFFFF:
  - MUL → 0x00000001, MULHU → 0xFFFFFFFE, MULH → 0x00000000.
  - Each has out_valid exactly 33 cycles after accept and in_ready 0 meanwhile.
- Divide corners:
  - DIV 7 / 0 → 0xFFFFFFFF; REM 7 / 0 → 7.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - DIV −7 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
- Handshake and flush:
  - out_ready held low 5 cycles → outputs stable.
  - Back-to-back base ops with out_ready = 1 → one result per cycle.
  - Flush at cycle 10 of a DIV → out_valid never rises; the next ADD completes normally.
- rst_n pulsed low mid-MULH → all outputs 0 immediately; a post-reset ADD 2+3 → 5.
